// File: rtl/perf_snapshot_reader.sv
// Snapshots three free-running performance counters and streams their
// deltas since the previous snapshot as three tagged words over valid/ready.
module perf_snapshot_reader #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Instruc_Reg,
  input  logic [WIDTH-1:0] MEM_Acc_Reg,
  input  logic [WIDTH-1:0] MEM_Correct_Reg,
  input  logic             snap_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             busy,
  output logic             done,
  output logic             snap_dropped
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_A = 2'd2,
    SEND_C = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] cur_i_q, cur_a_q, cur_c_q;
  logic [WIDTH-1:0] cur_i_d, cur_a_d, cur_c_d;
  logic [WIDTH-1:0] prev_i_q, prev_a_q, prev_c_q;
  logic [WIDTH-1:0] dlt_i_q, dlt_a_q, dlt_c_q;

  logic capture;
  logic done_q, done_d;
  logic drop_q, drop_d;

  // Modular subtraction: a counter that wrapped once still yields its true increment.
  function automatic logic [WIDTH-1:0] wrap_delta(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] prev);
    return cur - prev;
  endfunction

  assign cur_i_d = capture ? Instruc_Reg     : cur_i_q;
  assign cur_a_d = capture ? MEM_Acc_Reg     : cur_a_q;
  assign cur_c_d = capture ? MEM_Correct_Reg : cur_c_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      cur_i_q  <= '0;
      cur_a_q  <= '0;
      cur_c_q  <= '0;
      prev_i_q <= '0;
      prev_a_q <= '0;
      prev_c_q <= '0;
      dlt_i_q  <= '0;
      dlt_a_q  <= '0;
      dlt_c_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      cur_i_q <= cur_i_d;
      cur_a_q <= cur_a_d;
      cur_c_q <= cur_c_d;
      // Deltas are frozen at capture so the outputs stay stable under backpressure.
      if (capture) begin
        dlt_i_q  <= wrap_delta(cur_i_d, prev_i_q);
        dlt_a_q  <= wrap_delta(cur_a_d, prev_a_q);
        dlt_c_q  <= wrap_delta(cur_c_d, prev_c_q);
        prev_i_q <= cur_i_d;
        prev_a_q <= cur_a_d;
        prev_c_q <= cur_c_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done_d  = 1'b0;
    drop_d  = snap_req && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = SEND_I;
        end
      end
      SEND_I: if (out_ready) state_d = SEND_A;
      SEND_A: if (out_ready) state_d = SEND_C;
      SEND_C: begin
        if (out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_sel   = 2'd0;
    out_data  = '0;
    case (state_q)
      SEND_I: begin
        out_valid = 1'b1;
        out_sel   = 2'd0;
        out_data  = dlt_i_q;
      end
      SEND_A: begin
        out_valid = 1'b1;
        out_sel   = 2'd1;
        out_data  = dlt_a_q;
      end
      SEND_C: begin
        out_valid = 1'b1;
        out_sel   = 2'd2;
        out_data  = dlt_c_q;
      end
      default: begin
        out_valid = 1'b0;
        out_sel   = 2'd0;
        out_data  = '0;
      end
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign snap_dropped = drop_q;

endmodule
